// File: rtl/decision_vote.sv
// Hard-decision stage for the CDR: majority-votes an odd window of phase-sign
// samples around each symbol mid-point and emits one bit per symbol.
module decision_vote #(
  parameter int NBP_W    = 6,
  parameter int MAX_VOTE = 7,
  parameter bit INVERT   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_phase,
  input  logic [NBP_W-1:0] i_nb_P,
  input  logic [3:0]       i_vote_len,
  input  logic [1:0]       i_adj,
  input  logic             i_flag,
  output logic             o_data,
  output logic             o_valid,
  output logic             o_flag,
  output logic [NBP_W-1:0] o_cnt
);

  localparam int AW = $clog2(MAX_VOTE + 1);

  function automatic logic [NBP_W-1:0] f_sat_n(input logic [NBP_W-1:0] n);
    return (n < NBP_W'(3)) ? NBP_W'(3) : n;
  endfunction

  // Vote length is forced odd and into [1, MAX_VOTE].
  function automatic logic [NBP_W-1:0] f_sat_l(input logic [3:0] v);
    int l;
    l = int'(v);
    if (l < 1) l = 1;
    if (l > MAX_VOTE) l = MAX_VOTE;
    if ((l % 2) == 0) l = l - 1;
    return NBP_W'(l);
  endfunction

  logic [NBP_W-1:0] r_cnt, r_n, r_l;
  logic [AW-1:0]    r_acc;
  logic             r_hold, r_first, r_flag_d, r_pend;
  logic             r_data, r_valid, r_flag;

  logic [NBP_W-1:0] w_n, w_l, w_d, w_hl, w_h, w_lo, w_hi, w_base, w_sum;
  logic             w_last, w_wrap, w_start, w_end, w_in_win, w_maj, w_rise;

  // The first edge after reset runs on the freshly loaded configuration.
  always_comb begin
    w_n      = r_first ? f_sat_n(i_nb_P) : r_n;
    w_l      = r_first ? f_sat_l(i_vote_len) : r_l;
    w_d      = (w_n - NBP_W'(1)) >> 1;
    w_hl     = (w_l - NBP_W'(1)) >> 1;
    w_h      = (w_hl < w_d) ? w_hl : w_d;
    w_lo     = w_d - w_h;
    w_hi     = w_d + w_h;
    w_last   = (r_cnt == w_n - NBP_W'(1));
    w_wrap   = w_last && !r_hold;
    w_in_win = (r_cnt >= w_lo) && (r_cnt <= w_hi);
    w_start  = !r_hold && (r_cnt == w_lo);
    w_end    = !r_hold && (r_cnt == w_hi);
    w_base   = w_start ? '0 : NBP_W'(r_acc);
    w_sum    = w_base + NBP_W'(i_phase);
    w_maj    = (w_sum > w_h);
    w_rise   = i_flag && !r_flag_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_n      <= NBP_W'(3);
      r_l      <= NBP_W'(1);
      r_acc    <= '0;
      r_hold   <= 1'b0;
      r_first  <= 1'b1;
      r_flag_d <= 1'b0;
      r_pend   <= 1'b0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_first  <= 1'b0;
      r_flag_d <= i_flag;
      if (r_first || w_wrap) begin
        r_n <= f_sat_n(i_nb_P);
        r_l <= f_sat_l(i_vote_len);
      end
      // Retard holds the last index one extra cycle; the held cycle is not voted.
      if (r_hold) begin
        r_hold <= 1'b0;
        r_cnt  <= '0;
      end else if (w_last) begin
        case (i_adj)
          2'b01:   r_cnt  <= NBP_W'(1);
          2'b10:   r_hold <= 1'b1;
          default: r_cnt  <= '0;
        endcase
      end else begin
        r_cnt <= r_cnt + NBP_W'(1);
      end
      if (w_start)
        r_acc <= AW'(i_phase);
      else if (!r_hold && w_in_win)
        r_acc <= r_acc + AW'(i_phase);
      r_valid <= w_end;
      if (w_end)
        r_data <= INVERT ? ~w_maj : w_maj;
      r_flag <= w_end && r_pend;
      if (w_rise)
        r_pend <= 1'b1;
      else if (w_end)
        r_pend <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_flag  = r_flag;
  assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_decision_vote.sv
// Randomized bench for decision_vote: two instances (direct and inverted
// polarity) checked every cycle against a symbol-level reference model.
module tb_decision_vote;

  localparam int NBP_W    = 6;
  localparam int MAX_VOTE = 7;

  logic             clk, rst_n, phase, flag;
  logic [NBP_W-1:0] nb;
  logic [3:0]       vl;
  logic [1:0]       adj;
  logic             d0, v0, f0, d1, v1, f1;
  logic [NBP_W-1:0] c0, c1;

  decision_vote #(.NBP_W(NBP_W), .MAX_VOTE(MAX_VOTE), .INVERT(1'b0)) u_dir (
    .i_clk(clk), .i_rst(rst_n), .i_phase(phase), .i_nb_P(nb), .i_vote_len(vl),
    .i_adj(adj), .i_flag(flag), .o_data(d0), .o_valid(v0), .o_flag(f0), .o_cnt(c0));

  decision_vote #(.NBP_W(NBP_W), .MAX_VOTE(MAX_VOTE), .INVERT(1'b1)) u_inv (
    .i_clk(clk), .i_rst(rst_n), .i_phase(phase), .i_nb_P(nb), .i_vote_len(vl),
    .i_adj(adj), .i_flag(flag), .o_data(d1), .o_valid(v1), .o_flag(f1), .o_cnt(c1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in symbol, captured samples, expected outputs.
  int m_cnt, m_n, m_l;
  bit m_first, m_hold, m_pend, m_fprev;
  bit samp [64];
  bit e_valid, e_data0, e_data1, e_flag;

  function automatic int sat_n(input int v);
    return (v < 3) ? 3 : v;
  endfunction

  function automatic int sat_l(input int v);
    int l;
    l = (v == 0) ? 1 : ((v > MAX_VOTE) ? MAX_VOTE : v);
    if (l % 2 == 0) l = l - 1;
    return l;
  endfunction

  function automatic int window_lo(input int n, input int l);
    int d, h;
    d = (n - 1) / 2;
    h = (l - 1) / 2;
    if (h > d) h = d;
    return d - h;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_n = 3; m_l = 1; m_first = 1; m_hold = 0;
    m_pend = 0; m_fprev = 0;
    e_valid = 0; e_data0 = 0; e_data1 = 0; e_flag = 0;
    foreach (samp[i]) samp[i] = 0;
  endtask

  task automatic model_step();
    int n, l, d, h, ones;
    bit maj, rise, load;
    n = m_first ? sat_n(int'(nb)) : m_n;
    l = m_first ? sat_l(int'(vl)) : m_l;
    d = (n - 1) / 2;
    h = (l - 1) / 2;
    if (h > d) h = d;
    e_valid = 0;
    if (!m_hold) begin
      samp[m_cnt] = phase;
      if (m_cnt == d + h) begin
        ones = 0;
        for (int i = d - h; i <= d + h; i++) ones += int'(samp[i]);
        maj = (ones > h);
        e_data0 = maj;
        e_data1 = !maj;
        e_valid = 1;
      end
    end
    rise = flag && !m_fprev;
    m_fprev = flag;
    e_flag = e_valid && m_pend;
    if (rise) m_pend = 1;
    else if (e_valid) m_pend = 0;
    load = m_first || (m_cnt == n - 1 && !m_hold);
    if (m_hold) begin
      m_hold = 0;
      m_cnt = 0;
    end else if (m_cnt == n - 1) begin
      if (adj == 2'b01) m_cnt = 1;
      else if (adj == 2'b10) m_hold = 1;
      else m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (load) begin
      m_n = sat_n(int'(nb));
      m_l = sat_l(int'(vl));
    end
    m_first = 0;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    chk_eq("valid_dir", 32'(v0), 32'(e_valid));
    chk_eq("valid_inv", 32'(v1), 32'(e_valid));
    chk_eq("data_dir",  32'(d0), 32'(e_data0));
    chk_eq("data_inv",  32'(d1), 32'(e_data1));
    chk_eq("flag_dir",  32'(f0), 32'(e_flag));
    chk_eq("flag_inv",  32'(f1), 32'(e_flag));
    chk_eq("cnt",       32'(c0), 32'(m_cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_data"},  32'({d0, d1}), 32'd0);
    chk_eq({tag, "_valid"}, 32'({v0, v1}), 32'd0);
    chk_eq({tag, "_flag"},  32'({f0, f1}), 32'd0);
    chk_eq({tag, "_cnt"},   32'(c0), 32'd0);
  endtask

  // mode 0 random, 1 ones at cnt 2..4, 2 one at cnt 2 only, 3 ones at cnt 2..3
  task automatic drive_inputs(input int mode, input bit adj_en);
    case (mode)
      1:       phase = (m_cnt >= 2 && m_cnt <= 4);
      2:       phase = (m_cnt == 2);
      3:       phase = (m_cnt == 2 || m_cnt == 3);
      default: phase = 1'($urandom_range(0, 1));
    endcase
    if ($urandom_range(0, 24) == 0) flag = ~flag;
    if (adj_en && window_lo(sat_n(int'(nb)), sat_l(int'(vl))) >= 1)
      adj = 2'($urandom_range(0, 3));
    else
      adj = 2'b00;
  endtask

  task automatic run(input int cfg_n, input int cfg_l, input int mode,
                     input bit adj_en, input int cycles);
    nb = NBP_W'(cfg_n);
    vl = 4'(cfg_l);
    for (int i = 0; i < cycles; i++) begin
      drive_inputs(mode, adj_en);
      step_cycle();
    end
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; phase = 0; flag = 0; adj = 0; nb = 6'd8; vl = 4'd3;
    model_reset();
    #12;
    chk_zero("rst");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    #3 rst_n = 1'b1;

    run(8, 3, 1, 1'b0, 64);
    run(8, 3, 2, 1'b0, 40);
    run(8, 3, 3, 1'b0, 40);
    run(8, 3, 0, 1'b1, 200);
    run(4, 7, 0, 1'b0, 60);
    run(4, 0, 0, 1'b1, 60);
    run(1, 5, 0, 1'b0, 60);
    for (int k = 0; k < 8; k++)
      run($urandom_range(0, 40), $urandom_range(0, 15), 0, 1'b1, 120);

    // Reset in the middle of an N=8, L=5 vote, then a fresh symbol.
    run(8, 5, 0, 1'b0, 20);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_cnt == 3) hit = 1;
      else begin
        drive_inputs(0, 1'b0);
        step_cycle();
      end
    end
    chk_eq("reach_cnt3", 32'(hit), 32'd1);
    #3 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(posedge clk); #1;
    chk_zero("mid_rst_hold");
    model_reset();
    #3 rst_n = 1'b1;
    run(8, 5, 0, 1'b0, 80);
    run(8, 3, 0, 1'b1, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
